// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out transmitter with valid/ready load and frame/last strobes.
// Define PISO_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_data,
  output logic             ser_frame,
  output logic             ser_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t           state, nxt_state;
  logic [WIDTH-1:0] sreg, nxt_sreg;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic             nxt_data, nxt_frame, nxt_last;
  logic             take;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par, nxt_par;
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= nxt_state;
  end

  // sreg holds the bits not yet presented; cnt is how many remain after the one on ser_data.
  always_comb begin
    nxt_state  = state;
    nxt_sreg   = sreg;
    nxt_cnt    = cnt;
    nxt_data   = 1'b0;
    nxt_frame  = 1'b0;
    nxt_last   = 1'b0;
    load_ready = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    nxt_par    = par;
`endif
    case (state)
      IDLE:   load_ready = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: load_ready = 1'b1;
`else
      SHIFT:  load_ready = (cnt == '0);
`endif
      default: load_ready = 1'b0;
    endcase
    take = load_valid && load_ready;

    if (take) begin
      nxt_state = SHIFT;
      nxt_sreg  = {load_data[WIDTH-2:0], 1'b0};
      nxt_cnt   = CW'(WIDTH - 1);
      nxt_data  = load_data[WIDTH-1];
      nxt_frame = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      nxt_par   = ^load_data;
`endif
    end else if (state == SHIFT && cnt != '0) begin
      nxt_sreg  = {sreg[WIDTH-2:0], 1'b0};
      nxt_cnt   = cnt - 1'b1;
      nxt_data  = sreg[WIDTH-1];
      nxt_frame = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      nxt_last  = 1'b0;
`else
      nxt_last  = (cnt == CW'(1));
`endif
`ifdef PISO_SERIALIZER_PARITY_EN
    end else if (state == SHIFT) begin
      nxt_state = PARITY;
      nxt_data  = par;
      nxt_frame = 1'b1;
      nxt_last  = 1'b1;
`endif
    end else begin
      nxt_state = IDLE;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sreg      <= '0;
      cnt       <= '0;
      ser_data  <= 1'b0;
      ser_frame <= 1'b0;
      ser_last  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      sreg      <= nxt_sreg;
      cnt       <= nxt_cnt;
      ser_data  <= nxt_data;
      ser_frame <= nxt_frame;
      ser_last  <= nxt_last;
`ifdef PISO_SERIALIZER_PARITY_EN
      par       <= nxt_par;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: queue-of-bits reference model checked every cycle,
// plus literal expectations on captured serial streams.
module tb_piso_serializer;
  localparam int WIDTH = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam bit PAR  = 1'b1;
  localparam int FLEN = WIDTH + 1;
`else
  localparam bit PAR  = 1'b0;
  localparam int FLEN = WIDTH;
`endif

  logic             clock, clear, load_valid, load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_data, ser_frame, ser_last, busy;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clock(clock), .clear(clear), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_data(ser_data), .ser_frame(ser_frame),
    .ser_last(ser_last), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word becomes a list of future serial bits; one leaves per clock.
  typedef struct packed {logic d; logic l;} ent_t;
  ent_t q[$];
  ent_t cur;
  logic cur_v = 1'b0;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      q.delete();
      cur_v = 1'b0;
    end else begin
      if (load_valid && q.size() == 0) begin
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back('{load_data[i], (i == 0) && !PAR});
        if (PAR) q.push_back('{^load_data, 1'b1});
      end
      if (q.size() > 0) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    chk("ser_data",   ser_data,   cur_v ? cur.d : 1'b0);
    chk("ser_frame",  ser_frame,  cur_v);
    chk("ser_last",   ser_last,   cur_v ? cur.l : 1'b0);
    chk("busy",       busy,       cur_v);
    chk("load_ready", load_ready, q.size() == 0);
  end

  // Stream capture for literal checks.
  logic [63:0] cap_d, cap_l;
  int cap_n = 0, cyc = 0, cap_first = 0, cap_end = 0;
  always @(negedge clock) begin
    cyc++;
    if (ser_frame) begin
      cap_d = {cap_d[62:0], ser_data};
      cap_l = {cap_l[62:0], ser_last};
      if (cap_n == 0) cap_first = cyc;
      cap_end = cyc;
      cap_n++;
    end
  end

  task automatic cap_clr();
    cap_d = '0; cap_l = '0; cap_n = 0;
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int k = 0;
    load_valid = 1'b1;
    load_data  = d;
    while (!load_ready && k < 100) begin
      cyc_wait(1);
      k++;
    end
    if (!load_ready) chk("ready_timeout", 0, 1);
    cyc_wait(1);
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b0; load_valid = 1'b0; load_data = '0;
    cap_clr();
    cyc_wait(3);
    chk("rst_ready", load_ready, 1);
    chk("rst_frame", ser_frame, 0);
    chk("rst_busy", busy, 0);
    clear = 1'b1;

    // idle hold
    cap_clr();
    cyc_wait(20);
    chk("idle_frames", cap_n, 0);
    chk("idle_ready", load_ready, 1);

    // single word
    cap_clr();
    send(8'hA5);
    cyc_wait(FLEN + 1);
    chk("a5_len", cap_n, FLEN);
    chk("a5_frame_end", ser_frame, 0);
    chk("a5_busy_end", busy, 0);
`ifdef PISO_SERIALIZER_PARITY_EN
    chk("a5_bits", cap_d[8:0], {8'hA5, 1'b0});
    chk("a5_last", cap_l[8:0], 9'h001);
`else
    chk("a5_bits", cap_d[7:0], 8'hA5);
    chk("a5_last", cap_l[7:0], 8'h01);
`endif

    // back-to-back with valid held
    cap_clr();
    send(8'hFF);
    send(8'h00);
    cyc_wait(FLEN + 1);
    chk("b2b_len", cap_n, 2 * FLEN);
    chk("b2b_gapless", cap_end - cap_first + 1, 2 * FLEN);
`ifdef PISO_SERIALIZER_PARITY_EN
    chk("b2b_bits", cap_d[17:0], {8'hFF, 1'b0, 8'h00, 1'b0});
    chk("b2b_last", cap_l[17:0], 18'h00201);
`else
    chk("b2b_bits", cap_d[15:0], 16'hFF00);
    chk("b2b_last", cap_l[15:0], 16'h0101);
`endif

    // backpressure during cycle 3 of a frame
    cap_clr();
    send(8'h81);
    cyc_wait(2);
    load_valid = 1'b1;
    load_data  = 8'h3C;
    #1;
    chk("bp_ready", load_ready, 0);
    send(8'h3C);
    cyc_wait(FLEN + 1);
    chk("bp_len", cap_n, 2 * FLEN);
    chk("bp_gapless", cap_end - cap_first + 1, 2 * FLEN);
`ifdef PISO_SERIALIZER_PARITY_EN
    chk("bp_bits", cap_d[17:0], {8'h81, 1'b0, 8'h3C, 1'b0});
`else
    chk("bp_bits", cap_d[15:0], {8'h81, 8'h3C});
`endif

    // asynchronous reset mid-frame
    send(8'hC3);
    cyc_wait(3);
    #2 clear = 1'b0;
    #1;
    chk("ar_frame", ser_frame, 0);
    chk("ar_data", ser_data, 0);
    chk("ar_last", ser_last, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", load_ready, 1);
    cyc_wait(2);
    clear = 1'b1;
    cap_clr();
    cyc_wait(10);
    chk("ar_quiet", cap_n, 0);

    // valid held across reset release: first accept only after clear=1
    clear = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h5A;
    cyc_wait(2);
    chk("rv_frame", ser_frame, 0);
    clear = 1'b1;
    cap_clr();
    cyc_wait(1);
    load_valid = 1'b0;
    cyc_wait(FLEN + 1);
    chk("rv_len", cap_n, FLEN);
`ifdef PISO_SERIALIZER_PARITY_EN
    chk("rv_bits", cap_d[8:0], {8'h5A, 1'b0});

    cap_clr();
    send(8'h07);
    cyc_wait(FLEN + 1);
    chk("p07_bits", cap_d[8:0], {8'h07, 1'b1});
    chk("p07_last", cap_l[8:0], 9'h001);
    cap_clr();
    send(8'h03);
    cyc_wait(FLEN + 1);
    chk("p03_bits", cap_d[8:0], {8'h03, 1'b0});
`else
    chk("rv_bits", cap_d[7:0], 8'h5A);
`endif

    cyc_wait(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. Drives a single-bit serial stream into a chain of D flip-flops that captures it at the far end.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Provides frame and last-bit strobes so the receiving register chain knows when a word is complete.
- Supports gapless back-to-back words.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- clear  input  1  asynchronous active-low reset; clear=0 forces reset state immediately.
- load_valid  input  1  upstream has a word on load_data.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word; sampled only on an accepted transfer.
- ser_data  output  1  serial bit, MSB first; registered.
- ser_frame  output  1  high on every cycle ser_data carries a valid frame bit; registered.
- ser_last  output  1  high on the final bit of a frame; registered.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE; shift register=0; bit counter=0.
  - ser_data=0, ser_frame=0, ser_last=0, busy=0.
  - load_ready=1 once state is IDLE, but no transfer is taken while clear=0.
- Accepted transfer: rising clock edge with load_valid=1 and load_ready=1. A held load_valid with load_ready=0 is not a transfer; load_data may change freely in that case.
- States:
  - IDLE → SHIFT on an accepted transfer.
  - SHIFT → SHIFT while bits remain.
  - SHIFT → IDLE after the last bit if no new transfer was accepted.
  - SHIFT → SHIFT (reloaded) if a new transfer was accepted on the last-bit cycle.
  - With PARITY_EN, the last-bit handling is done by a PARITY state; see Optional Feature.
- Latency: on the first edge after an accepted transfer, ser_data=load_data[WIDTH-1] and ser_frame=1. The word is shifted out over WIDTH consecutive cycles, MSB to LSB.
- ser_last=1 only on the cycle carrying load_data[0] (or the parity bit with PARITY_EN). ser_frame stays 1 for the whole frame.
- load_ready:
  - 1 in IDLE.
  - 1 on the final-bit cycle of a frame, for gapless streaming.
  - 0 otherwise.
  - Derived combinationally from state/counter only, never from load_valid.
- Back-to-back: a transfer accepted on the last-bit cycle makes the next word's MSB appear on the very next cycle. ser_frame stays high with no idle gap, and ser_last pulses once per word.
- End of frame with no new transfer: next cycle ser_frame=0, ser_last=0, ser_data=0, busy=0.
- Bit counter: ceil(log2(WIDTH+1)) bits. Counts WIDTH-1 down to 0. It never wraps; it reloads only on an accepted transfer.
- busy=1 from the cycle after acceptance through the last-bit cycle inclusive.
- Reset mid-frame: clear=0 aborts immediately. The partial frame is discarded, and outputs take reset values asynchronously without waiting for a clock edge. After clear returns to 1, the block waits in IDLE for a new transfer.
- load_valid asserted during reset release: not accepted until the first rising edge with clear=1.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - After the LSB, one extra PARITY cycle drives ser_data = even parity (XOR of all WIDTH bits), with ser_frame=1 and ser_last=1.
  - The LSB cycle has ser_last=0.
  - Frame length is WIDTH+1 cycles; load_ready is 1 only on the PARITY cycle (and in IDLE).
- Not defined: PARITY state and parity logic are absent; frame length is WIDTH cycles.

Test Plan:
- Single word, WIDTH=8: reset, load 8'hA5 in IDLE.
  - Next 8 cycles: ser_data = 1,0,1,0,0,1,0,1; ser_frame=1 throughout; ser_last=1 only on cycle 8.
  - Cycle 9: ser_frame=0, busy=0.
- Back-to-back: hold load_valid=1 with 8'hFF then 8'h00.
  - Second transfer is accepted on the last-bit cycle of the first word.
  - Output is 16 contiguous frame cycles: eight 1s then eight 0s; ser_last pulses on cycles 8 and 16; ser_frame never drops.
- Backpressure: assert load_valid with 8'h3C during cycle 3 of an active frame.
  - load_ready=0 and no transfer until the last-bit cycle.
  - 8'h3C is then serialized starting the next cycle as 0,0,1,1,1,1,0,0.
- Reset mid-frame: clear=0 asynchronously during bit 4 of 8'hC3.
  - All outputs go to 0 without a clock edge.
  - After clear=1 with load_valid=0: ser_frame stays 0 for 10 cycles.
- Parity, PISO_SERIALIZER_PARITY_EN defined:
  - 8'h07 → bits 0,0,0,0,0,1,1,1 then parity bit 1; ser_last on cycle 9 only.
  - 8'h03 → parity bit 0.
- Idle hold: load_valid=0 for 20 cycles after reset → load_ready=1, busy=0, ser_frame=0, ser_data=0 every cycle.
